oled_layer_sequencer: RTL and testbench

//  Frame-synchronous controller for the 96x64 OLED pixel path (6.25 MHz domain).
//  - Tracks the scan position (x,y) with counters, so no %96 or /96 logic is needed.
//  - Latches per-layer enables only at frame boundaries, so frames never tear.
//  - Issues per-layer motion-step strobes every STEP_FRAMES frames.
//  - Arbitrates NUM_LAYERS sprite layers onto the single pixel_data bus by fixed priority.

---
 rtl/oled_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/oled_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_oled_layer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED pixel-path controller.
//   OLED_W / OLED_H / OLED_NPIX : panel geometry (96 x 64 = 6144 pixels)
//   X_W / Y_W / IDX_W           : counter and pixel-index widths derived from it
//   state_t                     : frame sequencer states
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int OLED_NPIX = OLED_W * OLED_H;

  localparam int X_W   = $clog2(OLED_W);
  localparam int Y_W   = $clog2(OLED_H);
  localparam int IDX_W = $clog2(OLED_NPIX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent, slowly changing levels
// (switch inputs). Bits are not guaranteed to cross on the same cycle.
//   clk     in  1      destination clock
//   reset_n in  1      asynchronous, active-low reset
//   d       in  WIDTH  asynchronous input levels
//   q       out WIDTH  synchronised levels, 2 cycles of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/oled_layer_sequencer.sv
// Frame-synchronous controller for the 96x64 OLED pixel path.
// Tracks the scan position with counters, latches the layer enables at each
// frame start, issues motion-step strobes every STEP_FRAMES frames and picks
// the highest-priority opaque layer colour for the pixel bus.
//   clk, reset_n     clock, asynchronous active-low reset
//   frame_begin      1-cycle frame start pulse
//   sending_pixels   high while the frame is being streamed
//   sample_pixel     1-cycle pulse: pixel_data is taken for pixel_index
//   pixel_index      pixel index 0..6143 reported by the display driver
//   layer_en_raw     asynchronous per-layer enable switches
//   layer_px         per-layer colours, layer i in [16i+15:16i]
//   x, y             registered scan column / row
//   pixel_data       arbitrated colour (combinational)
//   move_tick        per-layer 1-cycle motion-step strobe
//   layer_en         enable mask frozen for the current frame
//   frame_cnt        8-bit wrapping frame counter
//   sync_err         sticky scan/pixel_index disagreement flag
module oled_layer_sequencer
  import oled_pkg::*;
#(
  parameter int          NUM_LAYERS  = 2,
  parameter int          STEP_FRAMES = 4,
  parameter logic [15:0] TRANSPARENT = 16'h0000,
  parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_begin,
  input  logic                    sending_pixels,
  input  logic                    sample_pixel,
  input  logic [IDX_W-1:0]        pixel_index,
  input  logic [NUM_LAYERS-1:0]   layer_en_raw,
  input  logic [16*NUM_LAYERS-1:0] layer_px,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [15:0]             pixel_data,
  output logic [NUM_LAYERS-1:0]   move_tick,
  output logic [NUM_LAYERS-1:0]   layer_en,
  output logic [7:0]              frame_cnt,
  output logic                    sync_err
);

  localparam logic [X_W-1:0] X_LAST    = X_W'(OLED_W - 1);
  localparam logic [7:0]     STEP_LAST = 8'(STEP_FRAMES - 1);

  state_t                  state_q, state_d;
  logic [NUM_LAYERS-1:0]   en_s;
  logic                    sending_q;
  logic                    sending_fall;
  logic [7:0]              step_cnt;
  logic [IDX_W-1:0]        scan_idx;

  sync_2ff #(.WIDTH(NUM_LAYERS)) u_en_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (layer_en_raw),
    .q       (en_s)
  );

  assign sending_fall = sending_q & ~sending_pixels;

  // 96*y + x built from shifts: 96*y = 64*y + 32*y.
  assign scan_idx = IDX_W'({y, 6'b0}) + IDX_W'({y, 5'b0}) + IDX_W'(x);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sending_q <= sending_pixels;
    end
  end

  // A frame_begin in any state (including mid-FRAME) starts a fresh frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_begin) state_d = FRAME;
      FRAME:   if (frame_begin) state_d = FRAME;
               else if (sending_fall) state_d = BLANK;
      BLANK:   if (frame_begin) state_d = FRAME;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      layer_en  <= '0;
      move_tick <= '0;
      frame_cnt <= '0;
      step_cnt  <= '0;
      sync_err  <= 1'b0;
    end else begin
      move_tick <= '0;
      if (frame_begin) begin
        // Frame start has priority over a coincident sample_pixel.
        x         <= '0;
        y         <= '0;
        layer_en  <= en_s;
        frame_cnt <= frame_cnt + 8'd1;
        if (step_cnt == STEP_LAST) begin
          step_cnt  <= '0;
          move_tick <= en_s;
        end else begin
          step_cnt <= step_cnt + 8'd1;
        end
      end else if (state_q == FRAME && sample_pixel) begin
        if (pixel_index != scan_idx) sync_err <= 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;  // 6-bit row wraps 63 -> 0 on its own
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Walk from lowest to highest priority so layer 0 overrides everything.
  always_comb begin
    pixel_data = BG_COLOUR;
    if (state_q != IDLE) begin
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        if (layer_en[i] && (layer_px[16*i +: 16] != TRANSPARENT))
          pixel_data = layer_px[16*i +: 16];
      end
    end
  end

endmodule

// File: tb/tb_oled_layer_sequencer.sv
module tb_oled_layer_sequencer;

  localparam int          NL = 2;
  localparam int          SF = 4;
  localparam logic [15:0] TR = 16'h0000;
  localparam logic [15:0] BG = 16'h0000;
  localparam int          NPIX = 96 * 64;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 frame_begin;
  logic                 sending_pixels;
  logic                 sample_pixel;
  logic [12:0]          pixel_index;
  logic [NL-1:0]        layer_en_raw;
  logic [16*NL-1:0]     layer_px;
  logic [6:0]           x;
  logic [5:0]           y;
  logic [15:0]          pixel_data;
  logic [NL-1:0]        move_tick;
  logic [NL-1:0]        layer_en;
  logic [7:0]           frame_cnt;
  logic                 sync_err;

  always #5 clk = ~clk;

  oled_layer_sequencer #(
    .NUM_LAYERS  (NL),
    .STEP_FRAMES (SF),
    .TRANSPARENT (TR),
    .BG_COLOUR   (BG)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .sample_pixel   (sample_pixel),
    .pixel_index    (pixel_index),
    .layer_en_raw   (layer_en_raw),
    .layer_px       (layer_px),
    .x              (x),
    .y              (y),
    .pixel_data     (pixel_data),
    .move_tick      (move_tick),
    .layer_en       (layer_en),
    .frame_cnt      (frame_cnt),
    .sync_err       (sync_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: linear pixel position, total frame count, enable history.
  int            m_state;   // 0 idle, 1 in frame, 2 blanking
  int            m_pos;
  int            m_frames;
  logic [NL-1:0] m_s1, m_s2, m_en, m_tick;
  bit            m_err;
  bit            m_prev_sp;

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_frames = 0;
    m_s1 = '0; m_s2 = '0; m_en = '0; m_tick = '0;
    m_err = 0; m_prev_sp = 0;
  endtask

  function automatic logic [15:0] exp_px();
    if (m_state == 0) return BG;
    for (int i = 0; i < NL; i++)
      if (m_en[i] && layer_px[16*i +: 16] !== TR) return layer_px[16*i +: 16];
    return BG;
  endfunction

  task automatic check_all();
    chk("x",         x,          m_pos % 96);
    chk("y",         y,          m_pos / 96);
    chk("pixel",     pixel_data, exp_px());
    chk("move_tick", move_tick,  m_tick);
    chk("layer_en",  layer_en,   m_en);
    chk("frame_cnt", frame_cnt,  m_frames % 256);
    chk("sync_err",  sync_err,   m_err);
  endtask

  // Advance the model by the inputs currently applied, clock, then compare.
  task automatic tick();
    logic [NL-1:0] n_s1, n_s2;
    if (!reset_n) begin
      model_reset();
    end else begin
      n_s1 = layer_en_raw;
      n_s2 = m_s1;
      if (frame_begin) begin
        m_pos = 0;
        m_en = m_s2;
        m_frames++;
        m_tick = (m_frames % SF == 0) ? m_s2 : '0;
        m_state = 1;
      end else begin
        m_tick = '0;
        if (m_state == 1 && sample_pixel) begin
          if (int'(pixel_index) != m_pos) m_err = 1;
          m_pos = (m_pos + 1) % NPIX;
        end
        if (m_state == 1 && m_prev_sp && !sending_pixels) m_state = 2;
      end
      m_prev_sp = sending_pixels;
      m_s1 = n_s1;
      m_s2 = n_s2;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_px();
    logic [15:0] p0, p1;
    p0 = 16'($urandom);
    p1 = 16'($urandom);
    if ($urandom % 3 == 0) p0 = '0;
    if ($urandom % 4 == 0) p1 = '0;
    layer_px = {p1, p0};
  endtask

  task automatic hold_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int idx;
    int n0, n1;
    reset_n = 1'b0; frame_begin = 1'b0; sending_pixels = 1'b0; sample_pixel = 1'b0;
    pixel_index = '0; layer_en_raw = '1; layer_px = {16'h1234, 16'h5678};
    model_reset();

    // Reset state, with opaque colours present on both layers.
    repeat (3) tick();
    chk("rst_pixel_bg", pixel_data, BG);
    chk("rst_sync_err", sync_err, 0);
    reset_n = 1'b1;

    // Full frame with matching indices and random sample gaps.
    repeat (3) tick();
    chk("idle_bg", pixel_data, BG);
    frame_begin = 1'b1; sending_pixels = 1'b1;
    tick();
    frame_begin = 1'b0;
    idx = 0;
    while (idx < NPIX) begin
      sample_pixel = ($urandom % 4) != 0;
      pixel_index = 13'(idx);
      rand_px();
      tick();
      if (sample_pixel) begin
        idx++;
        if (idx == NPIX - 1) begin
          chk("last_x", x, 95);
          chk("last_y", y, 63);
        end
      end
    end
    sample_pixel = 1'b0;
    chk("wrap_x", x, 0);
    chk("wrap_y", y, 0);
    chk("clean_sync", sync_err, 0);
    sending_pixels = 1'b0;
    repeat (2) tick();

    // Skipped pixel index 100 -> 102 sets a sticky error.
    frame_begin = 1'b1; sending_pixels = 1'b1;
    tick();
    frame_begin = 1'b0;
    for (int i = 0; i < 150; i++) begin
      sample_pixel = 1'b1;
      pixel_index = 13'((i < 101) ? i : i + 1);
      tick();
      if (i == 100) chk("no_err_before_skip", sync_err, 0);
      if (i == 101) chk("err_at_skip", sync_err, 1);
    end
    sample_pixel = 1'b0; sending_pixels = 1'b0;
    repeat (2) tick();
    frame_begin = 1'b1; sending_pixels = 1'b1;
    tick();
    frame_begin = 1'b0;
    chk("err_sticky", sync_err, 1);
    hold_reset(2);
    chk("err_cleared", sync_err, 0);

    // Priority arbitration with both layers enabled.
    layer_en_raw = 2'b11;
    repeat (3) tick();
    frame_begin = 1'b1; sending_pixels = 1'b1;
    tick();
    frame_begin = 1'b0;
    layer_px = {16'h07E0, 16'hF800};
    tick();
    chk("prio_l0", pixel_data, 16'hF800);
    layer_px = {16'h07E0, 16'h0000};
    tick();
    chk("prio_l1", pixel_data, 16'h07E0);
    layer_px = {16'h0000, 16'h0000};
    tick();
    chk("prio_bg", pixel_data, BG);

    // Mid-frame switch drop only takes effect at the next frame start.
    layer_px = {16'h07E0, 16'hF800};
    layer_en_raw = 2'b10;
    repeat (5) tick();
    chk("hold_l0", pixel_data, 16'hF800);
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    chk("en_dropped", layer_en, 2'b10);
    chk("after_drop", pixel_data, 16'h07E0);

    // Motion ticks over 12 frames with layer 1 disabled.
    hold_reset(2);
    layer_en_raw = 2'b01;
    repeat (3) tick();
    n0 = 0; n1 = 0;
    for (int f = 0; f < 12; f++) begin
      frame_begin = 1'b1; sending_pixels = 1'b1;
      tick();
      frame_begin = 1'b0;
      n0 += int'(move_tick[0]); n1 += int'(move_tick[1]);
      for (int c = 0; c < 15; c++) begin
        sample_pixel = $urandom % 2;
        pixel_index = 13'(m_pos);
        rand_px();
        tick();
        sample_pixel = 1'b0;
        n0 += int'(move_tick[0]); n1 += int'(move_tick[1]);
      end
    end
    chk("tick0_count", n0, 3);
    chk("tick1_count", n1, 0);
    chk("frame_cnt_12", frame_cnt, 12);

    // frame_begin coinciding with sample_pixel, then async reset mid-frame.
    for (int c = 0; c < 10; c++) begin
      sample_pixel = 1'b1;
      pixel_index = 13'(m_pos);
      tick();
    end
    frame_begin = 1'b1; sample_pixel = 1'b1; pixel_index = 13'(m_pos);
    tick();
    frame_begin = 1'b0; sample_pixel = 1'b0;
    chk("fb_sp_x", x, 0);
    chk("fb_sp_y", y, 0);
    for (int c = 0; c < 7; c++) begin
      sample_pixel = 1'b1;
      pixel_index = 13'(m_pos);
      tick();
    end
    sample_pixel = 1'b0;
    layer_px = {16'h07E0, 16'hF800};
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_bg", pixel_data, BG);
    chk("async_rst_x", x, 0);
    hold_reset(2);

    // Random operation.
    for (int c = 0; c < 3000; c++) begin
      frame_begin = ($urandom % 150) == 0;
      if ($urandom % 100 == 0) sending_pixels = ~sending_pixels;
      sample_pixel = $urandom % 2;
      pixel_index = 13'(m_pos);
      if ($urandom % 700 == 0) pixel_index = pixel_index + 13'd1;
      if ($urandom % 60 == 0) layer_en_raw = 2'($urandom);
      rand_px();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
